// File: rtl/tlul_pkg.sv
// Shared TileLink-UL definitions: default widths, opcode encodings, responder
// FSM states and the byte-lane mask helper used by both bus ends.
package tlul_pkg;

  localparam int TL_AW    = 12;
  localparam int TL_DW    = 32;
  localparam int TL_SRCW  = 4;
  localparam int TL_SZW   = 2;
  localparam int TL_DEPTH = 256;

  localparam logic [2:0] PUT_FULL        = 3'd0;
  localparam logic [2:0] PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] GET             = 3'd4;
  localparam logic [2:0] ACCESS_ACK      = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } tlul_state_e;

  // Lanes covered by a 2^size-byte transfer starting at byte offset addr_lo
  // within an (up to) 8-lane bus word.
  function automatic logic [7:0] lane_mask(input logic [2:0] addr_lo,
                                           input logic [2:0] size);
    logic [2:0] sz;
    logic [8:0] ones;
    sz   = (size > 3'd3) ? 3'd3 : size;
    ones = (9'd1 << (4'd1 << sz)) - 9'd1;
    return ones[7:0] << addr_lo;
  endfunction

endpackage

// File: rtl/tlul_slave_mem.sv
// Word-organised RAM with per-byte write enables, synchronous write and
// combinational read. Contents are intentionally not reset.
module tlul_slave_mem #(
  parameter int DW    = 32,
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [DW/8-1:0]          be,
  input  logic [DW-1:0]            wdata,
  output logic [DW-1:0]            rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < DW/8; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/tlul_slave.sv
// TileLink-UL responder: checks A-channel requests, services them from a
// byte-enabled RAM and returns a registered D response one cycle later.
module tlul_slave
  import tlul_pkg::*;
#(
  parameter int AW    = TL_AW,
  parameter int DW    = TL_DW,
  parameter int SRCW  = TL_SRCW,
  parameter int SZW   = TL_SZW,
  parameter int DEPTH = TL_DEPTH
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_a_valid,
  output logic            o_a_ready,
  input  logic [2:0]      i_a_opcode,
  input  logic [2:0]      i_a_param,
  input  logic [SZW-1:0]  i_a_size,
  input  logic [SRCW-1:0] i_a_source,
  input  logic [AW-1:0]   i_a_address,
  input  logic [DW/8-1:0] i_a_mask,
  input  logic [DW-1:0]   i_a_data,
  output logic            o_d_valid,
  input  logic            i_d_ready,
  output logic [2:0]      o_d_opcode,
  output logic [2:0]      o_d_param,
  output logic [SZW-1:0]  o_d_size,
  output logic [SRCW-1:0] o_d_source,
  output logic            o_d_sink,
  output logic [DW-1:0]   o_d_data,
  output logic            o_d_error
);

  localparam int NB  = DW / 8;
  localparam int OFFW = $clog2(NB);
  localparam int MAW = $clog2(DEPTH);

  // Reset asserts immediately but releases on a clock edge.
  logic [1:0] rst_sync;
  logic       rst;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) rst_sync <= 2'b11;
    else         rst_sync <= {rst_sync[0], 1'b0};
  end

  assign rst = rst_sync[1];

  tlul_state_e state, state_nxt;
  logic        a_hs;

  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    o_a_ready = 1'b0;
    case (state)
      IDLE: begin
        o_a_ready = !rst;
        if (i_a_valid && !rst) state_nxt = RESP;
      end
      RESP: begin
        o_a_ready = i_d_ready;
        if (i_d_ready && !i_a_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign a_hs = i_a_valid && o_a_ready;

  // ---- p0: request decode and legality checks ----
  logic       is_get, is_pf, is_pp, err;
  logic [7:0] addr_lo, align_m, lanes, mask8;

  assign is_get  = (i_a_opcode == GET);
  assign is_pf   = (i_a_opcode == PUT_FULL);
  assign is_pp   = (i_a_opcode == PUT_PARTIAL);
  assign addr_lo = 8'(i_a_address) & 8'(NB - 1);
  assign align_m = (8'd1 << i_a_size) - 8'd1;
  assign lanes   = lane_mask(addr_lo[2:0], 3'(i_a_size));
  assign mask8   = 8'(i_a_mask);

  assign err = !(is_get || is_pf || is_pp)
            || (i_a_param != 3'd0)
            || (32'(i_a_size) > 32'(OFFW))
            || ((addr_lo & align_m) != 8'd0)
            || (32'(i_a_address) >= 32'(DEPTH * NB))
            || ((mask8 & ~lanes) != 8'd0)
            || (is_pf && (mask8 != lanes));

  logic          mem_we;
  logic [DW-1:0] rdata;

  assign mem_we = a_hs && (is_pf || is_pp) && !err;

  tlul_slave_mem #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (i_clk),
    .we    (mem_we),
    .idx   (i_a_address[OFFW +: MAW]),
    .be    (i_a_mask),
    .wdata (i_a_data),
    .rdata (rdata)
  );

  // ---- p1: registered D response, held until accepted ----
  logic [2:0]      d_opcode_p1;
  logic [SZW-1:0]  d_size_p1;
  logic [SRCW-1:0] d_source_p1;
  logic [DW-1:0]   d_data_p1;
  logic            d_error_p1;

  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      d_opcode_p1 <= '0;
      d_size_p1   <= '0;
      d_source_p1 <= '0;
      d_data_p1   <= '0;
      d_error_p1  <= 1'b0;
    end else if (a_hs) begin
      d_opcode_p1 <= is_get ? ACCESS_ACK_DATA : ACCESS_ACK;
      d_size_p1   <= i_a_size;
      d_source_p1 <= i_a_source;
      d_data_p1   <= (is_get && !err) ? rdata : '0;
      d_error_p1  <= err;
    end
  end

  assign o_d_valid  = (state == RESP);
  assign o_d_opcode = d_opcode_p1;
  assign o_d_param  = 3'd0;
  assign o_d_size   = d_size_p1;
  assign o_d_source = d_source_p1;
  assign o_d_sink   = 1'b0;
  assign o_d_data   = d_data_p1;
  assign o_d_error  = d_error_p1;

endmodule

// File: tb/tb_tlul_slave.sv
// Directed bench for tlul_slave: vector table of single transactions plus
// back-pressure, streaming and mid-response reset sequences.
module tb_tlul_slave;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        a_valid = 1'b0;
  logic        a_ready;
  logic [2:0]  a_opcode = 3'd0;
  logic [2:0]  a_param = 3'd0;
  logic [1:0]  a_size = 2'd0;
  logic [3:0]  a_source = 4'd0;
  logic [11:0] a_address = 12'd0;
  logic [3:0]  a_mask = 4'd0;
  logic [31:0] a_data = 32'd0;
  logic        d_valid;
  logic        d_ready = 1'b1;
  logic [2:0]  d_opcode;
  logic [2:0]  d_param;
  logic [1:0]  d_size;
  logic [3:0]  d_source;
  logic        d_sink;
  logic [31:0] d_data;
  logic        d_error;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tlul_slave dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_a_valid   (a_valid),
    .o_a_ready   (a_ready),
    .i_a_opcode  (a_opcode),
    .i_a_param   (a_param),
    .i_a_size    (a_size),
    .i_a_source  (a_source),
    .i_a_address (a_address),
    .i_a_mask    (a_mask),
    .i_a_data    (a_data),
    .o_d_valid   (d_valid),
    .i_d_ready   (d_ready),
    .o_d_opcode  (d_opcode),
    .o_d_param   (d_param),
    .o_d_size    (d_size),
    .o_d_source  (d_source),
    .o_d_sink    (d_sink),
    .o_d_data    (d_data),
    .o_d_error   (d_error)
  );

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  param;
    logic [1:0]  size;
    logic [3:0]  src;
    logic [11:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
    logic [2:0]  e_op;
    logic        e_err;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive_a(input vec_t v);
    a_valid   = 1'b1;
    a_opcode  = v.op;
    a_param   = v.param;
    a_size    = v.size;
    a_source  = v.src;
    a_address = v.addr;
    a_mask    = v.mask;
    a_data    = v.data;
  endtask

  // One isolated transaction with the master always ready on D.
  task automatic send_vec(input vec_t v, input string tag);
    @(negedge clk);
    d_ready = 1'b1;
    drive_a(v);
    chk({tag, "_a_ready"}, 32'(a_ready), 32'd1);
    @(posedge clk);
    #1 a_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_d_valid"}, 32'(d_valid), 32'd1);
    chk({tag, "_opcode"}, 32'(d_opcode), 32'(v.e_op));
    chk({tag, "_error"}, 32'(d_error), 32'(v.e_err));
    chk({tag, "_data"}, d_data, v.e_data);
    chk({tag, "_source"}, 32'(d_source), 32'(v.src));
    chk({tag, "_size"}, 32'(d_size), 32'(v.size));
    @(posedge clk);
  endtask

  initial begin
    vec_t v;
    vecs[0]  = '{3'd0, 3'd0, 2'd2, 4'd3, 12'h010, 4'hF, 32'hDEADBEEF, 3'd0, 1'b0, 32'h0};
    vecs[1]  = '{3'd4, 3'd0, 2'd2, 4'd5, 12'h010, 4'hF, 32'h0,        3'd1, 1'b0, 32'hDEADBEEF};
    vecs[2]  = '{3'd1, 3'd0, 2'd0, 4'd1, 12'h011, 4'h2, 32'h0000AA00, 3'd0, 1'b0, 32'h0};
    vecs[3]  = '{3'd4, 3'd0, 2'd2, 4'd2, 12'h010, 4'hF, 32'h0,        3'd1, 1'b0, 32'hDEADAAEF};
    vecs[4]  = '{3'd4, 3'd0, 2'd2, 4'd6, 12'h402, 4'hF, 32'h0,        3'd1, 1'b1, 32'h0};
    vecs[5]  = '{3'd2, 3'd0, 2'd2, 4'd7, 12'h010, 4'hF, 32'h12345678, 3'd0, 1'b1, 32'h0};
    vecs[6]  = '{3'd4, 3'd0, 2'd2, 4'd8, 12'h400, 4'hF, 32'h0,        3'd1, 1'b1, 32'h0};
    vecs[7]  = '{3'd0, 3'd0, 2'd2, 4'd9, 12'h010, 4'h7, 32'h11111111, 3'd0, 1'b1, 32'h0};
    vecs[8]  = '{3'd4, 3'd1, 2'd2, 4'hA, 12'h010, 4'hF, 32'h0,        3'd1, 1'b1, 32'h0};
    vecs[9]  = '{3'd4, 3'd0, 2'd3, 4'hB, 12'h010, 4'hF, 32'h0,        3'd1, 1'b1, 32'h0};
    vecs[10] = '{3'd1, 3'd0, 2'd0, 4'hC, 12'h012, 4'h1, 32'h000000FF, 3'd0, 1'b1, 32'h0};
    vecs[11] = '{3'd4, 3'd0, 2'd2, 4'hD, 12'h010, 4'hF, 32'h0,        3'd1, 1'b0, 32'hDEADAAEF};
    vecs[12] = '{3'd0, 3'd0, 2'd2, 4'hE, 12'h020, 4'hF, 32'h01020304, 3'd0, 1'b0, 32'h0};
    vecs[13] = '{3'd1, 3'd0, 2'd1, 4'hF, 12'h022, 4'hC, 32'hBEEF0000, 3'd0, 1'b0, 32'h0};
    vecs[14] = '{3'd4, 3'd0, 2'd2, 4'h0, 12'h020, 4'hF, 32'h0,        3'd1, 1'b0, 32'hBEEF0304};
    vecs[15] = '{3'd0, 3'd0, 2'd2, 4'h1, 12'h3FC, 4'hF, 32'h5A5AA5A5, 3'd0, 1'b0, 32'h0};
    vecs[16] = '{3'd4, 3'd0, 2'd2, 4'h2, 12'h3FC, 4'hF, 32'h0,        3'd1, 1'b0, 32'h5A5AA5A5};
    vecs[17] = '{3'd0, 3'd0, 2'd2, 4'h4, 12'h000, 4'hF, 32'h13579BDF, 3'd0, 1'b0, 32'h0};
    vecs[18] = '{3'd0, 3'd0, 2'd2, 4'h5, 12'h400, 4'hF, 32'hFFFFFFFF, 3'd0, 1'b1, 32'h0};
    vecs[19] = '{3'd4, 3'd0, 2'd2, 4'h6, 12'h000, 4'hF, 32'h0,        3'd1, 1'b0, 32'h13579BDF};

    #2 reset = 1'b1;
    #1;
    chk("rst_d_valid", 32'(d_valid), 32'd0);
    chk("rst_d_opcode", 32'(d_opcode), 32'd0);
    chk("rst_d_data", d_data, 32'd0);
    chk("rst_d_error", 32'(d_error), 32'd0);
    chk("rst_d_source", 32'(d_source), 32'd0);
    chk("rst_d_param_sink", {28'd0, d_param, d_sink}, 32'd0);
    chk("rst_a_ready", 32'(a_ready), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_a_ready", 32'(a_ready), 32'd1);
    chk("idle_d_valid", 32'(d_valid), 32'd0);

    for (int i = 0; i < 20; i++) send_vec(vecs[i], $sformatf("v%0d", i));

    // Back-pressure: response held, A blocked, then overlapped handshakes.
    @(negedge clk);
    d_ready = 1'b0;
    v = '{3'd4, 3'd0, 2'd2, 4'h4, 12'h010, 4'hF, 32'h0, 3'd1, 1'b0, 32'hDEADAAEF};
    drive_a(v);
    @(posedge clk);
    #1;
    v = '{3'd4, 3'd0, 2'd2, 4'hB, 12'h020, 4'hF, 32'h0, 3'd1, 1'b0, 32'hBEEF0304};
    drive_a(v);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_d_valid", c), 32'(d_valid), 32'd1);
      chk($sformatf("bp%0d_a_ready", c), 32'(a_ready), 32'd0);
      chk($sformatf("bp%0d_data", c), d_data, 32'hDEADAAEF);
      chk($sformatf("bp%0d_source", c), 32'(d_source), 32'h4);
    end
    d_ready = 1'b1;
    #1 chk("bp_release_a_ready", 32'(a_ready), 32'd1);
    @(posedge clk);
    #1 a_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_d_valid", 32'(d_valid), 32'd1);
    chk("bp_next_source", 32'(d_source), 32'hB);
    chk("bp_next_data", d_data, 32'hBEEF0304);
    @(posedge clk);
    @(negedge clk);
    chk("bp_drain_d_valid", 32'(d_valid), 32'd0);

    // Streaming: 16 Puts then 16 Gets, one per cycle.
    d_ready = 1'b1;
    v = '{3'd0, 3'd0, 2'd2, 4'd0, 12'h100, 4'hF, 32'hA5A50000, 3'd0, 1'b0, 32'h0};
    drive_a(v);
    for (int k = 0; k < 32; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("st%0d_d_valid", k), 32'(d_valid), 32'd1);
      chk($sformatf("st%0d_source", k), 32'(d_source), 32'(k % 16));
      chk($sformatf("st%0d_opcode", k), 32'(d_opcode), (k < 16) ? 32'd0 : 32'd1);
      chk($sformatf("st%0d_data", k), d_data, (k < 16) ? 32'd0 : (32'hA5A50000 | 32'(k - 16)));
      chk($sformatf("st%0d_a_ready", k), 32'(a_ready), 32'd1);
      if (k < 31) begin
        v.op   = (k + 1 < 16) ? 3'd0 : 3'd4;
        v.src  = 4'((k + 1) % 16);
        v.addr = 12'h100 + 12'(4 * ((k + 1) % 16));
        v.data = (k + 1 < 16) ? (32'hA5A50000 | 32'(k + 1)) : 32'h0;
        drive_a(v);
      end else begin
        a_valid = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("st_drain_d_valid", 32'(d_valid), 32'd0);

    // Reset while a write response is pending.
    d_ready = 1'b0;
    v = '{3'd0, 3'd0, 2'd2, 4'h2, 12'h030, 4'hF, 32'hCAFEF00D, 3'd0, 1'b0, 32'h0};
    drive_a(v);
    @(posedge clk);
    #1 a_valid = 1'b0;
    @(negedge clk);
    chk("rr_pending_d_valid", 32'(d_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("rr_async_d_valid", 32'(d_valid), 32'd0);
    chk("rr_async_source", 32'(d_source), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("rr_after_d_valid", 32'(d_valid), 32'd0);
    v = '{3'd4, 3'd0, 2'd2, 4'h9, 12'h030, 4'hF, 32'h0, 3'd1, 1'b0, 32'hCAFEF00D};
    send_vec(v, "rr_get");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tlul_slave.md
Name: tlul_slave

Overview:
- TileLink-UL responder: the other end of tlulMaster.
- Accepts A-channel requests (Get, PutFullData, PutPartialData) and services them from an internal byte-enabled register memory.
- Returns AccessAck or AccessAckData on the D channel.
- Serves as the bus target for master-side benches and miters, and as a simple on-chip RAM peripheral.

Parameters:
- AW, 12, A-channel address width in bits.
- DW, 32, data width in bits (power of two, 8..64).
- SRCW, 4, source ID width.
- SZW, 2, size field width.
- DEPTH, 256, memory depth in DW-bit words; valid byte range is 0..DEPTH*DW/8-1.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_a_valid  in  1  A request valid.
- o_a_ready  out  1  A request accepted when high together with i_a_valid.
- i_a_opcode  in  3  0=PutFullData, 1=PutPartialData, 4=Get.
- i_a_param  in  3  must be 0.
- i_a_size  in  SZW  log2 of transfer bytes.
- i_a_source  in  SRCW  requester ID.
- i_a_address  in  AW  byte address.
- i_a_mask  in  DW/8  byte lanes.
- i_a_data  in  DW  write data.
- o_d_valid  out  1  D response valid.
- i_d_ready  in  1  master accepts D.
- o_d_opcode  out  3  0=AccessAck, 1=AccessAckData.
- o_d_param  out  3  always 0.
- o_d_size  out  SZW  echoed a_size.
- o_d_source  out  SRCW  echoed a_source.
- o_d_sink  out  1  always 0.
- o_d_data  out  DW  read data; 0 for writes and errors.
- o_d_error  out  1  request denied.

Behaviour:
- Reset (async assert, sync deassert internally):
  - o_d_valid=0; all o_d_* fields 0; state IDLE.
  - Memory contents are not reset; the bench initialises them by writing.
- FSM IDLE/RESP:
  - IDLE: o_a_ready=1. On handshake, evaluate the request, perform the write or read, load the D register, go to RESP.
  - RESP: o_d_valid=1. o_a_ready = i_d_ready, so back-to-back traffic runs at full throughput. On D handshake with a simultaneous A handshake, stay in RESP with the new response loaded. On D handshake without a new A request, go to IDLE.
- Latency: response is valid exactly 1 cycle after the A handshake. D fields are held stable while o_d_valid && !i_d_ready.
- Word index: i_a_address[AW-1:log2(DW/8)].
- Error checks (any true -> o_d_error=1, no memory write, o_d_data=0):
  - unsupported opcode;
  - a_param!=0;
  - a_size>log2(DW/8);
  - address not aligned to 2^a_size;
  - address >= DEPTH*DW/8;
  - mask has a bit outside the lanes addressed by address/size;
  - PutFullData mask not exactly equal to those lanes.
- Error responses still use the opcode matching the request: AccessAckData for Get, AccessAck for Put.
- Write: bytes with mask=1 are updated at the handshake edge. AccessAck.
- Get: o_d_data = the full word read after any same-cycle write has completed. Get and Put are never simultaneous, so no hazard exists. All lanes are returned and the master selects.
- i_d_ready high with o_d_valid low is ignored.
- Reset mid-transaction drops the pending response. A write already accepted stays committed.
- o_a_ready does not depend combinationally on i_a_valid.

Decomposition:
- Shared package tlul_pkg holds:
  - A opcodes: PUT_FULL=0, PUT_PARTIAL=1, GET=4.
  - D opcodes: ACCESS_ACK=0, ACCESS_ACK_DATA=1.
  - Default widths.
  - Function lane_mask(addr, size) returning the DW/8-bit lane mask, shared with tlulMaster.
- One sub-module, tlul_slave_mem: DEPTH x DW synchronous-write / combinational-read array with per-byte enables.
- Request checking and the FSM stay in tlul_slave.

Test Plan:
- Reset asserted mid-RESP -> o_d_valid drops to 0 asynchronously. The following Get of a word written before reset returns the written data.
- PutFullData addr=0x10 size=2 mask=0xF data=0xDEADBEEF src=3, then Get addr=0x10 size=2 src=5:
  - first response: AccessAck, error 0, source 3, data 0;
  - second response: AccessAckData, data 0xDEADBEEF, source 5.
- PutPartialData addr=0x11 size=0 mask=0x2 data=0x0000AA00 over 0xDEADBEEF, then Get 0x10 -> data 0xDEADAAEF.
- Back-pressure: i_d_ready=0 for 3 cycles after a Get -> o_a_ready=0 and the D fields stay stable. Setting i_d_ready=1 with i_a_valid=1 gives simultaneous handshakes, and the next response appears the following cycle.
- Errors, each -> o_d_error=1 and memory unchanged:
  - Get addr=0x402 size=2: misaligned, AccessAckData with data 0;
  - opcode=2 -> AccessAck;
  - address 0x400 with DEPTH=256 -> out of range;
  - PutFullData size=2 mask=0x7 -> mask not full.
- Streaming: 16 consecutive Puts then 16 Gets with i_d_ready tied high -> one response per cycle, sources echoed in order, all data matches.
